// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared widths, constants and types for the SRAM-backed FIFO controller
package sram_fifo_pkg;
    localparam int DATA_WIDTH = 56;
    localparam int ADDR_WIDTH = 7;
    localparam int NUM_WMASKS = 4;
    localparam int OBUF_DEPTH = 3;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [7:0]            level_t;

    localparam level_t                  SRAM_DEPTH = 8'd128;
    localparam logic [NUM_WMASKS-1:0]   WMASK_ALL  = 4'hF;
endpackage

// File: rtl/sram_fifo_ctrl_128x56_obuf.sv
// rtl/sram_fifo_ctrl_128x56_obuf.sv - small in-order register FIFO holding words captured from SRAM dout1
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = OBUF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     cnt_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        wr_idx_d = push_i ? nxt(wr_idx_q) : wr_idx_q;
        rd_idx_d = pop_i  ? nxt(rd_idx_q) : rd_idx_q;
        cnt_d    = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_idx_q] <= data_i;
    end

    assign data_o = mem_q[rd_idx_q];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/sram_fifo_ctrl_128x56.sv
// rtl/sram_fifo_ctrl_128x56.sv - valid/ready FIFO controller driving a 1w1r 128x56 SRAM plus output buffer
module sram_fifo_ctrl_128x56 #(
    parameter int DATA_WIDTH = sram_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_fifo_pkg::ADDR_WIDTH,
    parameter int NUM_WMASKS = sram_fifo_pkg::NUM_WMASKS,
    parameter int OBUF_DEPTH = sram_fifo_pkg::OBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [7:0]              level,
    output logic                    sram_csb0,
    output logic [NUM_WMASKS-1:0]   sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
);
    import sram_fifo_pkg::*;

    logic [ADDR_WIDTH-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    level_t                           sram_cnt_q, sram_cnt_d;
    logic                             inflight_q, inflight_d;
    logic [$clog2(OBUF_DEPTH+1)-1:0]  obuf_cnt;
    logic                             push, pop, rd_issue;

    assign in_ready = !rst && (sram_cnt_q < SRAM_DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Output-buffer credit counts the in-flight read, so a pop never feeds the read issue path.
    assign rd_issue = !rst && (sram_cnt_q != '0) &&
                      ((level_t'(obuf_cnt) + level_t'(inflight_q)) < level_t'(OBUF_DEPTH));

    always_comb begin
        wr_ptr_d   = push     ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        inflight_d = rd_issue;
        sram_cnt_d = sram_cnt_q;
        case ({push, rd_issue})
            2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
            2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
            default: sram_cnt_d = sram_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));
        end
    end

    sram_fifo_obuf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .data_i (sram_dout1),
        .pop_i  (pop),
        .data_o (out_data),
        .cnt_o  (obuf_cnt)
    );

    assign out_valid   = !rst && (obuf_cnt != '0);
    assign level       = rst ? '0 : sram_cnt_q + level_t'(inflight_q) + level_t'(obuf_cnt);
    assign sram_csb0   = !push;
    assign sram_wmask0 = WMASK_ALL;
    assign sram_addr0  = wr_ptr_q;
    assign sram_din0   = in_data;
    assign sram_csb1   = !rd_issue;
    assign sram_addr1  = rd_ptr_q;
endmodule

// File: tb/tb_sram_fifo_ctrl_128x56.sv
// tb/tb_sram_fifo_ctrl_128x56.sv - directed and random scoreboard bench for sram_fifo_ctrl_128x56
module tb_sram_fifo_ctrl_128x56;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] out_data;
    logic [7:0]  level;
    logic        sram_csb0;
    logic [3:0]  sram_wmask0;
    logic [6:0]  sram_addr0;
    logic [55:0] sram_din0;
    logic        sram_csb1;
    logic [6:0]  sram_addr1;
    logic [55:0] sram_dout1 = '0;

    always #5 clk = ~clk;

    sram_fifo_ctrl_128x56 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .sram_csb0   (sram_csb0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    // SRAM behavioural model: read data appears the cycle after the read is issued.
    logic [55:0] mem [128];
    always @(posedge clk) begin
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    end

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [55:0] sb [$];
    int          model_lvl = 0;
    logic [6:0]  m_wptr = '0;
    logic [6:0]  m_rptr = '0;
    bit          chk_lvl = 1'b0;
    int          n_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [55:0] e;
        #1;
        if (chk_lvl) check("level", level, model_lvl);
        check("wmask", sram_wmask0, 4'hF);
        if (!sram_csb0) begin check("addr0", sram_addr0, m_wptr); m_wptr++; end
        if (!sram_csb1) begin check("addr1", sram_addr1, m_rptr); m_rptr++; end
        if (in_valid && in_ready) begin sb.push_back(in_data); model_lvl++; end
        if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e);
            end
            model_lvl--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 600 && sb.size() != 0; i++) tick();
        tick();
        check("drained", sb.size(), 0);
        check("drained_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 56'h0; out_ready = 1'b0;
        @(negedge clk);
        repeat (2) begin
            #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_csb0", sram_csb0, 1);
            check("rst_csb1", sram_csb1, 1);
            check("rst_level", level, 0);
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);
        tick();

        // single word latency
        in_valid = 1'b1; in_data = 56'h00_1234_5678_9ABC;
        #1; check("sw_csb0", sram_csb0, 0); check("sw_addr0", sram_addr0, 0);
        check("sw_din0", sram_din0, 56'h00_1234_5678_9ABC);
        tick();
        in_valid = 1'b0;
        #1; check("sw_csb1", sram_csb1, 0); check("sw_addr1", sram_addr1, 0);
        tick();
        #1 check("sw_c2_valid", out_valid, 0);
        tick();
        #1; check("sw_c3_valid", out_valid, 1);
        check("sw_c3_data", out_data, 56'h00_1234_5678_9ABC); check("sw_c3_level", level, 1);
        tick();
        #1; check("sw_hold_valid", out_valid, 1); check("sw_hold_level", level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1 check("sw_popped_level", level, 0);
        chk_lvl = 1'b1;

        // sustained stream, wraps both pointers
        out_ready = 1'b1;
        for (int k = 0; k < 303; k++) begin
            in_valid = (k < 300);
            in_data  = 56'(k + 1);
            if (k >= 3) begin #1 check("stream_valid", out_valid, 1); end
            tick();
        end
        drain();

        // fill to capacity
        out_ready = 1'b0;
        for (int k = 0; k < 140; k++) begin
            in_valid = 1'b1;
            in_data  = 56'h00F0_0000_0000 + 56'(k);
            tick();
        end
        check("fill_accepted", model_lvl, 131);
        in_valid = 1'b0;
        #1; check("full_in_ready", in_ready, 0); check("full_level", level, 131);
        tick();
        out_ready = 1'b1;
        #1 check("full_pop_valid", out_valid, 1);
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 56'h00AB_CDEF_0123_4567;
        #1; check("refill_issue", sram_csb1, 0); check("refill_rdy0", in_ready, 0);
        tick();
        #1 check("refill_rdy1", in_ready, 1);
        tick();
        #1 check("refill_rdy2", in_ready, 0);
        tick();
        tick();
        check("fill_one_more", model_lvl, 131);
        drain();

        // random traffic
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {24'($urandom), $urandom};
            out_ready = 1'($urandom_range(0, 1));
            #1 if (in_valid && in_ready) n_acc++;
            tick();
        end
        check("rand_count", n_acc, 2000);
        drain();

        // mid-run reset with a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            in_valid = 1'b1;
            in_data  = 56'h0050_0000_0000 + 56'(k);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1 check("mr_issue", sram_csb1, 0);
        tick();
        rst = 1'b1; chk_lvl = 1'b0;
        #1; check("mr_rst_level", level, 0); check("mr_rst_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        sb.delete(); model_lvl = 0; m_wptr = '0; m_rptr = '0; chk_lvl = 1'b1;
        #1; check("mr_after_level", level, 0); check("mr_after_valid", out_valid, 0);
        in_valid = 1'b1; in_data = 56'h00C0_FFEE_0000_0001;
        #1 check("mr_addr0", sram_addr0, 0);
        tick();
        in_valid = 1'b0;
        #1 check("mr_c1_valid", out_valid, 0);
        tick();
        #1 check("mr_c2_valid", out_valid, 0);
        tick();
        #1; check("mr_c3_valid", out_valid, 1); check("mr_c3_data", out_data, 56'h00C0_FFEE_0000_0001);
        drain();
        check("final_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
